// File: rtl/riscv_pkg.sv
// Shared decode constants, issue FSM state type and queue payload type.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_JALR = 1'b1
  } issue_state_t;

  // One buffered fetch: PC and instruction word.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

  // Major opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] get_opcode(input logic [INST_W-1:0] inst);
    return inst[OPC_W-1:0];
  endfunction

endpackage

// File: rtl/issue_ctrl_inst_queue.sv
// In-order instruction queue: circular buffer of {pc,inst} with occupancy count.
module inst_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 i_en,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  iq_entry_t            i_data,
  output iq_entry_t            o_head,
  output logic [DEPTH_LOG:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam int unsigned CNT_W = DEPTH_LOG + 1;

  iq_entry_t              r_mem [DEPTH];
  logic [DEPTH_LOG-1:0]   r_rd_ptr;
  logic [DEPTH_LOG-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]       r_count;

  logic                   w_do_push;
  logic                   w_do_pop;

  // Qualified push/pop: never write a full queue or read an empty one.
  always_comb begin
    w_do_push = i_push && !o_full;
    w_do_pop  = i_pop && !o_empty;
  end

  // Status and head view.
  always_comb begin
    o_full  = (r_count == CNT_W'(DEPTH));
    o_empty = (r_count == CNT_W'(0));
    o_count = r_count;
    o_head  = r_mem[r_rd_ptr];
  end

  // Pointers and count; pointer width makes them wrap modulo DEPTH.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG'(1);
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk_in) begin
    if (i_en && !i_clear && w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue sequencer: buffers fetches, issues the head to RS/LSB and RoB, serialises after JALR.
module issue_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned IQ_DEPTH_LOG = 2,
  parameter int unsigned TAG_W        = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_inst,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  output logic              dec_valid,
  output logic [31:0]       dec_inst,
  output logic [31:0]       dec_pc,
  input  logic              dec_need_LSB,
  input  logic              RS_full,
  input  logic              LSB_full,
  input  logic              RoB_full,
  input  logic              RoB_stall,
  output logic              issue_rob,
  output logic              issue_rs,
  output logic              issue_lsb,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              jalr_done_in,
  input  logic              flush_in,
  input  logic [TAG_W-1:0]  flush_tag_in
);

  localparam int unsigned IQ_DEPTH = 1 << IQ_DEPTH_LOG;
  localparam int unsigned CNT_W    = IQ_DEPTH_LOG + 1;

  issue_state_t        r_state;
  issue_state_t        w_state_nxt;
  logic [TAG_W-1:0]    r_tag;

  iq_entry_t           w_head;
  iq_entry_t           w_fetch_entry;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_stall;
  logic                w_push;
  logic                w_jalr_clear;
  logic                w_clear;
  logic                w_head_is_jalr;

  // Queue handshake, head presentation and issue decision.
  always_comb begin
    w_fetch_entry.pc   = fetch_pc;
    w_fetch_entry.inst = fetch_inst;

    fetch_ready = (w_count < CNT_W'(IQ_DEPTH));
    dec_valid   = !w_empty && (r_state == RUN);
    dec_inst    = w_head.inst;
    dec_pc      = w_head.pc;

    w_stall   = RoB_full || RoB_stall || (dec_need_LSB ? LSB_full : RS_full);
    issue_rob = rdy_in && !flush_in && dec_valid && !w_stall;
    issue_rs  = issue_rob && !dec_need_LSB;
    issue_lsb = issue_rob && dec_need_LSB;
    issue_tag = r_tag;

    w_head_is_jalr = (get_opcode(w_head.inst) == OPC_JALR);
    w_jalr_clear   = (r_state == WAIT_JALR) && jalr_done_in;
    w_clear        = flush_in || w_jalr_clear;
    w_push         = fetch_valid && !w_full && !flush_in && rdy_in;
  end

  inst_queue #(
    .DEPTH_LOG (IQ_DEPTH_LOG)
  ) u_iq (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_en    (rdy_in),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (issue_rob),
    .i_data  (w_fetch_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Issue FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= RUN;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: flush wins, issued JALR blocks issue until its target resolves.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_in) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN:       if (issue_rob && w_head_is_jalr) w_state_nxt = WAIT_JALR;
        WAIT_JALR: if (jalr_done_in)                w_state_nxt = RUN;
        default:                                    w_state_nxt = RUN;
      endcase
    end
  end

  // RoB tag counter: reload on flush, advance on each issue.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_tag <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_tag <= flush_tag_in;
      end else if (issue_rob) begin
        r_tag <= r_tag + TAG_W'(1);
      end
    end
  end

endmodule
